// File: rtl/exe_mem_stage.sv
// exe_mem_stage: EXE->MEM pipeline register with a req/ack data-memory access unit.
// One word load/store per captured instruction; a stuck access is aborted after TIMEOUT_CYCLES.
module exe_mem_stage #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ena,
    input  logic [31:0] exe_alu_result,
    input  logic        exe_alu_nochange,
    input  logic [31:0] exe_mem_addr,
    input  logic [31:0] exe_GPR_rt,
    input  logic        exe_mem_rd,
    input  logic        exe_mem_wr,
    input  logic        exe_GPR_we,
    input  logic [4:0]  exe_GPR_waddr,
    input  logic [1:0]  exe_GPR_wsel,
    input  logic [31:0] exe_pc,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        mem_busy,
    output logic        mem_addr_err,
    output logic        mem_bus_err,
    output logic        mem_GPR_we,
    output logic [4:0]  mem_GPR_waddr,
    output logic [31:0] mem_GPR_wdata
);
    localparam int CW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic {IDLE, REQ} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic [31:0]   alu_q, pc_q, rdata_q, addr_q, wdata_q;
    logic [4:0]    waddr_q;
    logic [1:0]    wsel_q;
    logic          we_q, nochange_q, err_q, req_q, dwe_q, addr_err_q, bus_err_q;
    logic          cap, mem_op, misal, issue, done, tout;

    assign cap    = (state_q == IDLE) && ena;
    assign mem_op = exe_mem_rd || exe_mem_wr;
    assign misal  = |exe_mem_addr[1:0];
    assign issue  = cap && mem_op && !misal;
    assign done   = (state_q == REQ) && dmem_ack;
    // ack has priority: timeout only fires on a cycle without ack
    assign tout   = (state_q == REQ) && !dmem_ack && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d = state_q;
        state_d = (state_q == IDLE) ? (issue ? REQ : IDLE) : ((done || tout) ? IDLE : REQ);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            alu_q      <= '0;
            pc_q       <= '0;
            rdata_q    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            waddr_q    <= '0;
            wsel_q     <= '0;
            we_q       <= 1'b0;
            nochange_q <= 1'b0;
            err_q      <= 1'b0;
            req_q      <= 1'b0;
            dwe_q      <= 1'b0;
            addr_err_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_err_q <= cap && mem_op && misal;
            bus_err_q  <= tout;
            if (cap) begin
                alu_q      <= exe_alu_result;
                nochange_q <= exe_alu_nochange;
                we_q       <= exe_GPR_we;
                waddr_q    <= exe_GPR_waddr;
                wsel_q     <= exe_GPR_wsel;
                pc_q       <= exe_pc;
                err_q      <= mem_op && misal;
            end
            if (issue) begin
                req_q   <= 1'b1;
                dwe_q   <= exe_mem_wr;
                addr_q  <= {exe_mem_addr[31:2], 2'b00};
                wdata_q <= exe_GPR_rt;
                cnt_q   <= '0;
            end else if (state_q == REQ) begin
                cnt_q <= cnt_q + CW'(1);
                if (done || tout) req_q <= 1'b0;
                if (done && !dwe_q) rdata_q <= dmem_rdata;
                if (tout) err_q <= 1'b1;
            end
        end
    end

    assign dmem_req      = req_q;
    assign dmem_we       = dwe_q;
    assign dmem_addr     = addr_q;
    assign dmem_wdata    = wdata_q;
    assign mem_busy      = (state_q == REQ);
    assign mem_addr_err  = addr_err_q;
    assign mem_bus_err   = bus_err_q;
    assign mem_GPR_we    = we_q && !nochange_q && !err_q && !mem_busy;
    assign mem_GPR_waddr = waddr_q;
    assign mem_GPR_wdata = (wsel_q == 2'b01) ? rdata_q :
                           (wsel_q == 2'b10) ? pc_q + 32'd8 : alu_q;
endmodule
